meas_scheduler: RTL and testbench

Downstream of the switch-to-mode control unit. Consumes the mutually exclusive level mode selects (start_watch / start_sr / start_dht) and turns them into paced, one-cycle trigger pulses for the HC-SR04 and DHT-11 controllers. Waits for each measurement's done, enforces the per-sensor minimum repeat period and a response timeout, and drives the display-source select.

---
 rtl/meas_pkg.sv | 42 ++++
 rtl/ms_tick.sv | 29 ++
 rtl/meas_scheduler.sv | 142 ++++++++++++++
 tb/tb_meas_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement scheduler: mode and FSM
// encodings, display-source codes and the millisecond-counter width.
package meas_pkg;

  localparam int unsigned MS_W = 12;
  localparam logic [MS_W-1:0] MS_MAX = '1;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_WATCH = 2'd1,
    MODE_SR    = 2'd2,
    MODE_DHT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [1:0] DISP_NONE = 2'b00;
  localparam logic [1:0] DISP_SR   = 2'b01;
  localparam logic [1:0] DISP_DHT  = 2'b10;

  // Multi-hot selects resolve with priority dht > sr > watch.
  function automatic mode_e decode_mode(input logic watch, input logic sr, input logic dht);
    if (dht)        return MODE_DHT;
    else if (sr)    return MODE_SR;
    else if (watch) return MODE_WATCH;
    else            return MODE_NONE;
  endfunction

  function automatic logic [1:0] disp_code(input mode_e m);
    case (m)
      MODE_SR:  return DISP_SR;
      MODE_DHT: return DISP_DHT;
      default:  return DISP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: one-cycle tick every DIV clocks, restartable by a
// synchronous clear.
module ms_tick #(
  parameter int unsigned DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_c = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/meas_scheduler.sv
// Turns level mode selects into paced one-cycle trigger pulses for the SR04
// and DHT11 controllers, with done/timeout handling and display selection.
module meas_scheduler
  import meas_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned SR_PERIOD_MS  = 100,
  parameter int unsigned DHT_PERIOD_MS = 2000,
  parameter int unsigned TIMEOUT_MS    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_watch,
  input  logic       start_sr,
  input  logic       start_dht,
  input  logic       sr_done,
  input  logic       dht_done,
  output logic       sr_trig,
  output logic       dht_trig,
  output logic [1:0] disp_sel,
  output logic       meas_busy,
  output logic       timeout_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam logic [MS_W-1:0] SR_PER  = MS_W'(SR_PERIOD_MS);
  localparam logic [MS_W-1:0] DHT_PER = MS_W'(DHT_PERIOD_MS);
  localparam logic [MS_W-1:0] TO_MS   = MS_W'(TIMEOUT_MS);

  mode_e           mode_d_c;
  mode_e           mode_q;
  mode_e           mode_prev_q;
  state_e          state_q;
  state_e          state_d;
  logic [MS_W-1:0] ms_cnt_q;
  logic [MS_W-1:0] ms_next_c;
  logic [MS_W-1:0] period_c;
  logic            tick_c;
  logic            clr_c;
  logic            done_c;
  logic            go_trig_c;
  logic            sr_trig_d;
  logic            dht_trig_d;
  logic            busy_d;
  logic            to_d;
  logic [7:0]      err_d;

  ms_tick #(.DIV(TICK_DIV)) u_ms_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_c),
    .tick_c (tick_c)
  );

  assign mode_d_c = decode_mode(start_watch, start_sr, start_dht);

  // Value ms_cnt takes at the coming edge, so thresholds land on exact clock counts.
  assign ms_next_c = (tick_c && (ms_cnt_q != MS_MAX)) ? ms_cnt_q + MS_W'(1) : ms_cnt_q;
  assign period_c  = (mode_q == MODE_DHT) ? DHT_PER : SR_PER;
  assign done_c    = ((mode_q == MODE_SR) && sr_done) || ((mode_q == MODE_DHT) && dht_done);

  always_comb begin
    state_d    = state_q;
    sr_trig_d  = 1'b0;
    dht_trig_d = 1'b0;
    busy_d     = meas_busy;
    to_d       = 1'b0;
    clr_c      = 1'b0;
    go_trig_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((mode_q == MODE_SR) || (mode_q == MODE_DHT)) go_trig_c = 1'b1;
      end
      ST_TRIG: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_c) begin
          state_d = ST_HOLD;
          busy_d  = 1'b0;
        end else if (tick_c && (ms_next_c == TO_MS)) begin
          state_d = ST_HOLD;
          busy_d  = 1'b0;
          to_d    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ms_next_c >= period_c) go_trig_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_trig_c) begin
      state_d    = ST_TRIG;
      sr_trig_d  = (mode_q == MODE_SR);
      dht_trig_d = (mode_q == MODE_DHT);
      busy_d     = 1'b1;
      clr_c      = 1'b1;
    end

    // A mode change outside IDLE abandons the measurement without flagging an error.
    if ((state_q != ST_IDLE) && (mode_q != mode_prev_q)) begin
      state_d    = ST_IDLE;
      sr_trig_d  = 1'b0;
      dht_trig_d = 1'b0;
      busy_d     = 1'b0;
      to_d       = 1'b0;
      clr_c      = 1'b0;
    end
  end

  assign err_d = (to_d && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NONE;
      mode_prev_q <= MODE_NONE;
      ms_cnt_q    <= '0;
      sr_trig     <= 1'b0;
      dht_trig    <= 1'b0;
      disp_sel    <= DISP_NONE;
      meas_busy   <= 1'b0;
      timeout_err <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d_c;
      mode_prev_q <= mode_q;
      ms_cnt_q    <= clr_c ? '0 : ms_next_c;
      sr_trig     <= sr_trig_d;
      dht_trig    <= dht_trig_d;
      disp_sel    <= disp_code(mode_d_c);
      meas_busy   <= busy_d;
      timeout_err <= to_d;
      err_cnt     <= err_d;
    end
  end

endmodule

// File: tb/tb_meas_scheduler.sv
// Directed bench for meas_scheduler with a 1 ms clock, so every cycle is a
// tick; cycle c is the interval following rising edge c.
module tb_meas_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_watch, start_sr, start_dht;
  logic       sr_done, dht_done;
  logic       sr_trig, dht_trig;
  logic [1:0] disp_sel;
  logic       meas_busy, timeout_err;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cy      = 0;
  logic any_trig;

  meas_scheduler #(
    .CLK_HZ        (1000),
    .SR_PERIOD_MS  (10),
    .DHT_PERIOD_MS (20),
    .TIMEOUT_MS    (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_watch (start_watch),
    .start_sr    (start_sr),
    .start_dht   (start_dht),
    .sr_done     (sr_done),
    .dht_done    (dht_done),
    .sr_trig     (sr_trig),
    .dht_trig    (dht_trig),
    .disp_sel    (disp_sel),
    .meas_busy   (meas_busy),
    .timeout_err (timeout_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cy%0d: observed %0h expected %0h", tag, cy, obs, exp);
    end
  endtask

  // Inputs changed here take effect in the current cycle; outputs read here belong to it.
  task automatic cyc();
    @(negedge clk);
    cy++;
  endtask

  task automatic run_to(input int c);
    while (cy < c) cyc();
  endtask

  initial begin
    rst_n = 1'b0; start_watch = 1'b0; start_sr = 1'b0; start_dht = 1'b0;
    sr_done = 1'b0; dht_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sr_trig",  8'(sr_trig), 8'h0);
    chk("rst_dht_trig", 8'(dht_trig), 8'h0);
    chk("rst_disp",     8'(disp_sel), 8'h0);
    chk("rst_busy",     8'(meas_busy), 8'h0);
    chk("rst_to",       8'(timeout_err), 8'h0);
    chk("rst_err",      err_cnt, 8'h0);

    // SR pacing: trigger at 2, done at 5, then triggers at 12 and 22
    rst_n = 1'b1; start_sr = 1'b1; cy = 0;
    run_to(1);  chk("sr_disp1", 8'(disp_sel), 8'h1);
                chk("sr_notrig1", 8'(sr_trig), 8'h0);
    run_to(2);  chk("sr_trig2", 8'(sr_trig), 8'h1);
                chk("sr_busy2", 8'(meas_busy), 8'h1);
                chk("sr_dht_quiet2", 8'(dht_trig), 8'h0);
    run_to(3);  chk("sr_trig3_low", 8'(sr_trig), 8'h0);
    run_to(5);  sr_done = 1'b1;
    cyc();      sr_done = 1'b0;
                chk("sr_busy6", 8'(meas_busy), 8'h0);
    run_to(11); chk("sr_trig11_low", 8'(sr_trig), 8'h0);
    run_to(12); chk("sr_trig12", 8'(sr_trig), 8'h1);
    run_to(15); sr_done = 1'b1;
    cyc();      sr_done = 1'b0;
    run_to(21); chk("sr_trig21_low", 8'(sr_trig), 8'h0);
    run_to(22); chk("sr_trig22", 8'(sr_trig), 8'h1);
                chk("sr_err22", err_cnt, 8'h0);

    // Foreign done ignored; done coinciding with the timeout tick wins
    run_to(25); dht_done = 1'b1;
    cyc();      dht_done = 1'b0;
                chk("stray_dht_busy", 8'(meas_busy), 8'h1);
    run_to(27); sr_done = 1'b1;
    cyc();      sr_done = 1'b0;
                chk("race_to", 8'(timeout_err), 8'h0);
                chk("race_err", err_cnt, 8'h0);
                chk("race_busy", 8'(meas_busy), 8'h0);
    run_to(32); chk("sr_trig32", 8'(sr_trig), 8'h1);
    run_to(37); chk("to37_low", 8'(timeout_err), 8'h0);
    run_to(38); chk("to38", 8'(timeout_err), 8'h1);
                chk("err38", err_cnt, 8'h1);
                chk("busy38", 8'(meas_busy), 8'h0);
    run_to(39); chk("to39_low", 8'(timeout_err), 8'h0);
    run_to(40); sr_done = 1'b1;
    cyc();      sr_done = 1'b0;
    run_to(42); chk("sr_trig42", 8'(sr_trig), 8'h1);

    // Switch to DHT while waiting: mode_q changes at 45
    run_to(44); start_sr = 1'b0; start_dht = 1'b1;
    run_to(45); chk("sw_disp45", 8'(disp_sel), 8'h2);
                chk("sw_busy45", 8'(meas_busy), 8'h1);
    run_to(46); chk("sw_busy46", 8'(meas_busy), 8'h0);
                sr_done = 1'b1;
    cyc();      sr_done = 1'b0;
                chk("sw_dht_trig47", 8'(dht_trig), 8'h1);
                chk("sw_sr_quiet47", 8'(sr_trig), 8'h0);
    run_to(48); chk("sw_no_to48", 8'(timeout_err), 8'h0);
                chk("sw_err48", err_cnt, 8'h1);

    // DHT with no done: timeout every period, saturating error count
    run_to(52); chk("dht_to52_low", 8'(timeout_err), 8'h0);
    run_to(53); chk("dht_to53", 8'(timeout_err), 8'h1);
                chk("dht_err53", err_cnt, 8'h2);
    run_to(66); chk("dht_trig66_low", 8'(dht_trig), 8'h0);
    run_to(67); chk("dht_trig67", 8'(dht_trig), 8'h1);
    run_to(253); chk("dht_to253", 8'(timeout_err), 8'h1);
                 chk("dht_err253", err_cnt, 8'd12);
    run_to(6100); chk("err_sat6100", err_cnt, 8'hFF);
    run_to(6200); chk("err_sat6200", err_cnt, 8'hFF);

    // Watch only: no triggers, display none
    start_dht = 1'b0; start_watch = 1'b1;
    run_to(6201); chk("watch_disp", 8'(disp_sel), 8'h0);
    any_trig = 1'b0;
    while (cy < 6240) begin
      cyc();
      if (sr_trig || dht_trig) any_trig = 1'b1;
    end
    chk("watch_no_trig", 8'(any_trig), 8'h0);
    chk("watch_busy", 8'(meas_busy), 8'h0);

    // Multi-hot: DHT takes priority
    start_sr = 1'b1; start_dht = 1'b1;
    run_to(6241); chk("multi_disp", 8'(disp_sel), 8'h2);
    any_trig = 1'b0;
    cyc();        chk("multi_dht_trig", 8'(dht_trig), 8'h1);
    while (cy < 6280) begin
      if (sr_trig) any_trig = 1'b1;
      cyc();
    end
    chk("multi_no_sr", 8'(any_trig), 8'h0);

    // Async reset in the middle of an SR wait
    start_dht = 1'b0; start_watch = 1'b0;
    run_to(6283); chk("pre_rst_trig", 8'(sr_trig), 8'h1);
    run_to(6285); chk("pre_rst_busy", 8'(meas_busy), 8'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 8'(meas_busy), 8'h0);
    chk("arst_err",  err_cnt, 8'h0);
    chk("arst_disp", 8'(disp_sel), 8'h0);
    chk("arst_trig", 8'(sr_trig | dht_trig), 8'h0);
    cyc();        rst_n = 1'b1;
    cyc();        chk("post_disp", 8'(disp_sel), 8'h1);
                  chk("post_notrig", 8'(sr_trig), 8'h0);
    cyc();        chk("post_trig", 8'(sr_trig), 8'h1);
                  chk("post_busy", 8'(meas_busy), 8'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
